// File: rtl/adc_sample_buffer_if.sv
// Sample stream from the ADC buffer toward the USB transfer logic.
// The buffer is the master (drives data/valid); the consumer drives ready.
interface adc_sample_buffer_if;
    logic [15:0] outputData;
    logic        outputValid;
    logic        outputReady;

    modport master (
        output outputData,
        output outputValid,
        input  outputReady
    );

    modport slave (
        input  outputData,
        input  outputValid,
        output outputReady
    );
endinterface

// File: rtl/adc_sample_buffer.sv
// Elastic buffer between the ADC converter and the USB transfer interface.
// Captures one sample per clock while collectData is high, optionally
// substituting a ramp test pattern, and drains over a valid/ready stream.
module adc_sample_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  collectData,
    input  logic                  testMode,
    input  logic [15:0]           inputData,
    adc_sample_buffer_if.master   usbPort,
    output logic [DEPTH_LOG2:0]   fillLevel,
    output logic                  overflow,
    output logic [31:0]           sampleCount
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = DEPTH[DEPTH_LOG2:0];

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic [9:0]            tc;
    logic                  collectPrev;

    logic                  readEn;
    logic                  isFull;
    logic                  writeEn;
    logic                  dropEn;
    logic                  captureStart;
    logic [15:0]           pattern;
    logic [15:0]           sampleIn;
    logic [DEPTH_LOG2-1:0] rdPtrNext;
    logic [DEPTH_LOG2:0]   fillNext;
    logic                  headBypass;

    // Handshake decode, source select and next-state arithmetic.
    always_comb begin
        readEn       = usbPort.outputValid & usbPort.outputReady;
        isFull       = (fillLevel == FULL_LEVEL);
        // A full FIFO still accepts when the head leaves in the same cycle.
        writeEn      = collectData & (~isFull | readEn);
        dropEn       = collectData & isFull & ~readEn;
        captureStart = collectData & ~collectPrev;
        // (tc - 512) * 64: subtracting 512 in 10 bits only flips the MSB.
        pattern      = {~tc[9], tc[8:0], 6'b000000};
        sampleIn     = testMode ? pattern : inputData;
        rdPtrNext    = rdPtr + DEPTH_LOG2'(readEn);
        fillNext     = fillLevel + (DEPTH_LOG2 + 1)'(writeEn)
                                 - (DEPTH_LOG2 + 1)'(readEn);
        // The incoming sample becomes the head when nothing else remains.
        headBypass   = writeEn & (fillLevel == (DEPTH_LOG2 + 1)'(readEn));
    end

    // Sample storage; written only when a sample is accepted.
    always_ff @(posedge clock) begin
        if (!reset && writeEn) begin
            mem[wrPtr] <= sampleIn;
        end
    end

    // Pointers, occupancy and the registered head/valid outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr               <= '0;
            rdPtr               <= '0;
            fillLevel           <= '0;
            usbPort.outputValid <= 1'b0;
            usbPort.outputData  <= 16'h0000;
        end else begin
            if (writeEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            rdPtr               <= rdPtrNext;
            fillLevel           <= fillNext;
            usbPort.outputValid <= (fillNext != '0);
            // Registered read at the look-ahead address keeps the head
            // current without a combinational path from the memory.
            if (headBypass) begin
                usbPort.outputData <= sampleIn;
            end else begin
                usbPort.outputData <= mem[rdPtrNext];
            end
        end
    end

    // Test-pattern counter runs only while capturing, from 0 each capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            tc          <= '0;
            collectPrev <= 1'b0;
        end else begin
            collectPrev <= collectData;
            if (collectData) begin
                tc <= tc + 1'b1;
            end else begin
                tc <= '0;
            end
        end
    end

    // Diagnostics: sticky overflow and accepted count, restarted on capture start.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow    <= 1'b0;
            sampleCount <= '0;
        end else if (captureStart) begin
            // Clearing wins over a drop; an accepted sample counts afresh.
            overflow    <= 1'b0;
            sampleCount <= {31'd0, writeEn};
        end else begin
            if (dropEn) begin
                overflow <= 1'b1;
            end
            if (writeEn) begin
                sampleCount <= sampleCount + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_adc_sample_buffer.sv
// Randomized and directed bench for adc_sample_buffer against a queue model.
module tb_adc_sample_buffer;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                collectData = 1'b0;
    logic                testMode = 1'b0;
    logic [15:0]         inputData = 16'h0000;
    logic [DEPTH_LOG2:0] fillLevel;
    logic                overflow;
    logic [31:0]         sampleCount;

    adc_sample_buffer_if usbIf ();

    adc_sample_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock       (clock),
        .reset       (reset),
        .collectData (collectData),
        .testMode    (testMode),
        .inputData   (inputData),
        .usbPort     (usbIf.master),
        .fillLevel   (fillLevel),
        .overflow    (overflow),
        .sampleCount (sampleCount)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int failCount  = 0;

    // Reference model state.
    logic [15:0] mq[$];
    int          mTc = 0;
    bit          mPrev = 1'b0;
    bit          mOvf = 1'b0;
    logic [31:0] mCount = 32'd0;

    // Samples the DUT actually handed over on the stream.
    logic [15:0] consumed[$];

    task automatic checkVal(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One clock of the behavioural model, using the inputs seen at the edge.
    task automatic modelStep();
        bit          start, rd, full, acc, drop;
        int          v;
        logic [31:0] vv;
        logic [15:0] sample;
        if (reset) begin
            mq.delete();
            mTc = 0; mPrev = 0; mOvf = 0; mCount = 0;
            return;
        end
        start = collectData && !mPrev;
        rd    = (mq.size() > 0) && usbIf.outputReady;
        full  = (mq.size() == DEPTH);
        v     = (mTc - 512) * 64;
        vv    = v;
        sample = testMode ? vv[15:0] : inputData;
        acc   = collectData && (!full || rd);
        drop  = collectData && !acc;
        if (rd) void'(mq.pop_front());
        if (acc) mq.push_back(sample);
        if (start) begin
            mOvf   = 0;
            mCount = acc ? 32'd1 : 32'd0;
        end else begin
            if (drop) mOvf = 1;
            if (acc) mCount = mCount + 32'd1;
        end
        mTc   = collectData ? (mTc + 1) % 1024 : 0;
        mPrev = collectData;
    endtask

    task automatic compareAll();
        checkVal("fillLevel", 32'(fillLevel), 32'(mq.size()));
        checkVal("outputValid", 32'(usbIf.outputValid), 32'(mq.size() > 0));
        checkVal("overflow", 32'(overflow), 32'(mOvf));
        checkVal("sampleCount", sampleCount, mCount);
        if (mq.size() > 0) checkVal("outputData", 32'(usbIf.outputData), 32'(mq[0]));
    endtask

    // Apply inputs, clock once, advance the model and compare outputs.
    task automatic tick(input bit r, input bit c, input bit t, input logic [15:0] d, input bit rdy);
        reset = r; collectData = c; testMode = t; inputData = d; usbIf.outputReady = rdy;
        if (!r && usbIf.outputValid && rdy) consumed.push_back(usbIf.outputData);
        @(posedge clock);
        modelStep();
        #1;
        compareAll();
    endtask

    initial begin
        usbIf.outputReady = 1'b0;

        // Reset held with capture requested: nothing may be written.
        for (int i = 0; i < 3; i++) tick(1, 1, 0, 16'h1234, 1);
        checkVal("rst_outputData", 32'(usbIf.outputData), 32'h0);
        checkVal("rst_outputValid", 32'(usbIf.outputValid), 32'h0);
        tick(0, 0, 0, 16'h0, 1);
        checkVal("rst_fill", 32'(fillLevel), 32'h0);
        checkVal("rst_count", sampleCount, 32'h0);
        checkVal("rst_overflow", 32'(overflow), 32'h0);

        // Ordering and one-cycle latency with a ramp on inputData.
        consumed.delete();
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 16'(i * 64), 1);
            checkVal("ord_fill_le1", 32'(fillLevel <= 1), 32'h1);
        end
        checkVal("ord_count", sampleCount, 32'd20);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 16'h0, 1);
        checkVal("ord_n", 32'(consumed.size()), 32'd20);
        for (int i = 0; i < 20 && i < consumed.size(); i++)
            checkVal("ord_data", 32'(consumed[i]), 32'(i * 64));

        // Test pattern over a full wrap of the counter.
        consumed.delete();
        for (int i = 0; i < 1030; i++) tick(0, 1, 1, 16'($urandom), 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 16'h0, 1);
        checkVal("pat_n", 32'(consumed.size()), 32'd1030);
        if (consumed.size() == 1030) begin
            checkVal("pat_first", 32'(consumed[0]), 32'h8000);
            checkVal("pat_second", 32'(consumed[1]), 32'h8040);
            checkVal("pat_mid", 32'(consumed[512]), 32'h0000);
            checkVal("pat_last", 32'(consumed[1023]), 32'h7FC0);
            checkVal("pat_wrap", 32'(consumed[1024]), 32'h8000);
            checkVal("pat_tail", 32'(consumed[1029]), 32'h8140);
        end

        // Fill to exactly full, then read and write together.
        for (int i = 0; i < 16; i++) tick(0, 1, 0, 16'(16'h2000 + i), 0);
        checkVal("full_fill", 32'(fillLevel), 32'd16);
        checkVal("full_ovf", 32'(overflow), 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 16'(16'h2100 + i), 1);
            checkVal("fullrw_fill", 32'(fillLevel), 32'd16);
            checkVal("fullrw_ovf", 32'(overflow), 32'h0);
        end
        checkVal("fullrw_count", sampleCount, 32'd26);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 16'h0, 1);

        // Overflow: 20 writes with no consumer.
        consumed.delete();
        for (int i = 0; i < 20; i++) begin
            tick(0, 1, 0, 16'(16'h1000 + i), 0);
            if (i < 16) checkVal("ovf_pre", 32'(overflow), 32'h0);
            if (i == 16) begin
                checkVal("ovf_fill", 32'(fillLevel), 32'd16);
                checkVal("ovf_set", 32'(overflow), 32'h1);
            end
        end
        checkVal("ovf_count", sampleCount, 32'd16);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 16'h0, 1);
        checkVal("ovf_drain_n", 32'(consumed.size()), 32'd16);
        for (int i = 0; i < 16 && i < consumed.size(); i++)
            checkVal("ovf_drain", 32'(consumed[i]), 32'(16'h1000 + i));
        checkVal("ovf_hold", 32'(overflow), 32'h1);

        // Restart clears diagnostics and restarts the pattern at 0x8000.
        tick(0, 1, 1, 16'h0, 1);
        checkVal("rs_ovf", 32'(overflow), 32'h0);
        checkVal("rs_count", sampleCount, 32'd1);
        checkVal("rs_valid", 32'(usbIf.outputValid), 32'h1);
        checkVal("rs_data", 32'(usbIf.outputData), 32'h8000);
        for (int i = 0; i < 5; i++) tick(0, 1, 1, 16'h0, 1);
        tick(0, 0, 0, 16'h0, 1);

        // Randomized traffic with shifting consumer pressure and rare resets.
        for (int p = 0; p < 10; p++) begin
            int readyBias = $urandom_range(10, 95);
            int collectBias = $urandom_range(30, 95);
            for (int i = 0; i < 250; i++) begin
                tick($urandom_range(0, 199) == 0,
                     $urandom_range(0, 99) < collectBias,
                     $urandom_range(0, 1) == 1,
                     16'($urandom),
                     $urandom_range(0, 99) < readyBias);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/adc_sample_buffer.md
# adc_sample_buffer

Elastic sample buffer placed directly downstream of the ADC data converter. Accepts one 16-bit signed sample per clock while capture is enabled, optionally substitutes a deterministic test pattern, and holds samples in a small synchronous FIFO. The FIFO drains toward the USB transfer interface over a valid/ready handshake. Reports fill level, a sticky overflow flag and an accepted-sample count for host diagnostics.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth; DEPTH = 2**DEPTH_LOG2 entries of 16 bits.
- clock  in  1  sample clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- collectData  in  1  capture enable; one sample is offered per clock while high.
- testMode  in  1  1 = replace inputData with the test pattern.
- inputData  in  16  signed sample from the converter, new value every clock.
- outputData  out  16  FIFO head sample; meaningful only while outputValid = 1.
- outputValid  out  1  FIFO non-empty.
- outputReady  in  1  consumer accepts outputData this cycle.
- fillLevel  out  DEPTH_LOG2+1  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- sampleCount  out  32  samples accepted into the FIFO since capture start.

## Operation
- Source select: sample = testMode ? pattern : inputData. Selection is combinational at the write port.
- Test pattern: 10-bit counter tc with pattern = (tc − 512) × 64 as 16-bit two's complement. tc=0 → 0x8000, tc=512 → 0x0000, tc=1023 → 0x7FC0.
  - tc advances every clock with collectData=1, including cycles where the sample is dropped. This makes gaps visible downstream.
  - tc wraps 1023→0. tc is held at 0 while collectData=0.
- Capture start: a rising edge of collectData (registered previous value 0, current 1) clears overflow and sampleCount on that same edge.
- Write attempt: every clock with collectData=1.
  - Accepted if fillLevel < DEPTH, or if fillLevel = DEPTH and a read occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
- Read: occurs when outputValid & outputReady. The head advances and the next entry is presented on the following cycle.
  - outputReady is ignored while outputValid=0.
- fillLevel update: fillLevel' = fillLevel + write − read. With a simultaneous accepted write and read, fillLevel is unchanged.
- Empty FIFO with a write: outputValid rises on the next edge. There is no same-cycle bypass.
- sampleCount increments by 1 per accepted write and wraps 0xFFFFFFFF→0.
- collectData falling: writes stop immediately. Buffered samples keep draining normally. overflow and sampleCount hold their values.
- Pointers: DEPTH_LOG2-bit read and write pointers wrapping modulo DEPTH. Full and empty are derived from fillLevel, not from pointer equality.

## Timing
- All outputs are registered.
- Reset values: outputData 0x0000, outputValid 0, fillLevel 0, overflow 0, sampleCount 0. Internally: tc 0, pointers 0, previous-collectData register 0.
- Reset asserted mid-operation discards all buffered data on that edge. Capture resumes only after reset deasserts and a collectData rising edge is seen.
  - If collectData is already high when reset deasserts, this counts as a rising edge.
- Latency: sample on inputData at edge N (FIFO empty) appears on outputData with outputValid=1 after edge N; it is consumable in cycle N+1.
- Throughput: 1 sample/clock sustained when outputReady is held high.
- overflow sets on the edge of the first dropped write. It clears only on reset or a capture start.
- Reset has priority over all other events. Capture-start clearing has priority over a same-cycle overflow set, so the sample is counted or dropped afresh.

## Test plan
- Reset check: assert reset for 3 clocks with collectData=1 and outputReady=1, then release with collectData=0. Required: all outputs at their reset values, and no writes occurred while reset was high.
- Ordering and latency: testMode=0, outputReady=1, inputData stepping 0x0000, 0x0040, 0x0080… with collectData high for 20 cycles. Required: identical sequence on outputData one cycle later, fillLevel ≤ 1, and sampleCount = 20.
- Test pattern: testMode=1, outputReady=1, collectData high for 1030 cycles. Required: outputData runs 0x8000, 0x8040, …, 0x7FC0, then wraps to 0x8000 at sample 1024.
- Overflow: DEPTH=16, outputReady=0, collectData high for 20 cycles. Required:
  - fillLevel = 16 and overflow=1 from the 17th write; sampleCount = 16.
  - Raising outputReady drains exactly the first 16 samples in order.
- Full with simultaneous read: with fillLevel=16, hold outputReady=1 and collectData=1. Required: writes accepted every cycle, fillLevel stays at 16, overflow stays 0.
- Restart: after the overflow case, drop collectData for 2 cycles, then raise it again. Required: overflow and sampleCount clear on the rising edge, and tc restarts at 0 (first pattern 0x8000).
